fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage of the five-stage core. It drives the fetch address into the multi-cycle instruction ROM and accepts a word only when the ROM pulses ready. Accepted words are buffered with their PC in a small FIFO and handed to decode over a valid/ready handshake. Branch/jump redirects from execute flush the buffer and restart fetch.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, instruction buffer entries (power of 2, >=2)
NOP, 32'h0000_0013, bubble word (addi x0,x0,0) driven when no valid instruction

Ports:
clk  in  1  single clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
mem_pc  out  32  fetch address to ROM; byte address, word aligned
mem_instr  in  32  ROM data word
mem_ready  in  1  ROM response strobe; one-cycle pulse, mem_instr valid for current mem_pc
redirect_valid  in  1  flush and restart request from execute
redirect_pc  in  32  new fetch address; bits[1:0] ignored, forced to 0
id_valid  out  1  buffer head holds a valid instruction
id_ready  in  1  decode accepts head this cycle
id_instr  out  32  head instruction; NOP when id_valid=0
id_pc  out  32  head PC; 0 when id_valid=0
count  out  $clog2(DEPTH)+1  buffered entries (debug/verification)

Behaviour:
- Reset (async assert, sync release): mem_pc=RESET_PC, buffer empty, count=0, id_valid=0, id_instr=NOP, id_pc=0, drop=1.
- drop flag: next mem_ready pulse is discarded, not pushed. Set by reset (ROM power-up ready carries no valid data) and by redirect. Cleared by the pulse it discards.
- Accept: cycle where mem_ready=1, drop=0, no redirect, and buffer not full (or a pop also occurs this cycle) -> push {mem_pc, mem_instr}; mem_pc <= mem_pc+4 on the same edge. 32-bit wrap at 32'hFFFF_FFFC -> 0.
- mem_pc changes only on an accept edge or on redirect; it is held stable between pulses. This is required because the ROM samples pc on its ready edge.
- Full: mem_ready while full with no pop -> word discarded, mem_pc held (word is refetched on the next pulse), drop unchanged.
- Pop: id_valid && id_ready -> head removed at the edge. Push and pop in the same cycle keep count constant. Full with simultaneous pop accepts the push.
- Output: id_valid = count!=0. id_instr/id_pc are combinational from the head entry. Zero latency from push edge to id_valid.
- Redirect (highest priority): at the edge, buffer cleared, count=0, mem_pc <= {redirect_pc[31:2],2'b00}, drop=1. Same-cycle mem_ready and id_ready are ignored (no push, no pop counted). Back-to-back redirects: last one wins, drop stays 1.
- Reset mid-operation: all state returns to reset values immediately, regardless of outstanding response.
- FSM view (explicit encoding allowed or derived from drop/count):
  - DROP: awaiting a pulse to discard; a pulse moves to RUN.
  - RUN: accepting pulses.
  - RUN with count==DEPTH is FULL. Pop returns to RUN. A pulse while FULL is discarded.
  - Redirect from any state goes to DROP.
- Throughput bound: one instruction per ROM pulse. Decode sees bubbles (NOP, id_valid=0) between pulses.

Test Plan:
- Reset/first pulse: release rst_n, ROM pulses ready with X data at cycle 1 -> discarded, count=0, mem_pc stays 0. Next pulse with word 0x00500093 -> id_valid=1, id_instr=0x00500093, id_pc=0, mem_pc=4.
- Streaming: id_ready=1, 4 pulses with words A,B,C,D -> decode receives A..D with id_pc 0,4,8,12 in order. id_instr=0x13 on every non-valid cycle.
- Full/backpressure: id_ready=0, DEPTH=2, 3 pulses -> count=2, third word discarded, mem_pc=8. Raise id_ready -> next pulse delivers word@8; no PC skipped or duplicated.
- Redirect: 1 entry buffered, redirect_valid with redirect_pc=0x0000_0042 -> count=0, id_valid=0, mem_pc=0x40. Next pulse dropped, following pulse pushed with id_pc=0x40.
- Simultaneous events: full, pop and mem_ready in same cycle -> push accepted, count stays 2. Redirect with mem_ready and id_ready together -> nothing pushed/popped, buffer empty.
- Async reset mid-stream: assert rst_n=0 between clock edges with count=2 -> outputs reset immediately (id_valid=0, mem_pc=RESET_PC) without waiting for clk. Wrap check: redirect to 0xFFFFFFFC, accept -> mem_pc=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: the ROM request/response, the execute redirect, and the decode handshake.
// The master modport belongs to fetch_unit and the slave modport to its environment.
interface fetch_unit_if #(
  parameter int DEPTH = 2
);
  logic [31:0]             mem_pc;
  logic [31:0]             mem_instr;
  logic                    mem_ready;
  logic                    redirect_valid;
  logic [31:0]             redirect_pc;
  logic                    id_valid;
  logic                    id_ready;
  logic [31:0]             id_instr;
  logic [31:0]             id_pc;
  logic [$clog2(DEPTH):0]  count;

  modport master (
    output mem_pc, id_valid, id_instr, id_pc, count,
    input  mem_instr, mem_ready, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  mem_pc, id_valid, id_instr, id_pc, count,
    output mem_instr, mem_ready, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: holds the PC steady for a multi-cycle ROM and buffers accepted words with their PC.
// Decode reads the buffer over valid/ready, and a redirect from execute flushes the buffer and restarts fetch.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  // DROP: the next ROM pulse is discarded. RUN: pulses are accepted, subject to buffer space.
  typedef enum logic {ST_DROP, ST_RUN} state_t;

  state_t           state_reg, state_next;
  logic [31:0]      mem_pc_reg;
  logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [31:0]      pc_buf   [DEPTH];
  logic [31:0]      instr_buf[DEPTH];

  logic             full;
  logic             flush;
  logic             push;
  logic             pop;

  assign full = (count_reg == CW'(DEPTH));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_DROP;
    else        state_reg <= state_next;
  end

  // Next-state logic. A redirect overrides everything; in DROP, any pulse is consumed.
  always_comb begin
    state_next = state_reg;
    if (bus.redirect_valid)
      state_next = ST_DROP;
    else if (state_reg == ST_DROP && bus.mem_ready)
      state_next = ST_RUN;
  end

  // Output logic: per-cycle control strobes.
  always_comb begin
    flush = bus.redirect_valid;
    pop   = 1'b0;
    push  = 1'b0;
    if (!flush) begin
      pop  = (count_reg != '0) && bus.id_ready;
      push = (state_reg == ST_RUN) && bus.mem_ready && (!full || pop);
    end
  end

  // The fetch PC moves only on an accepted word or on a redirect, so the ROM always sees a stable address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_pc_reg <= RESET_PC;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      mem_pc_reg <= {bus.redirect_pc[31:2], 2'b00};
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        mem_pc_reg <= mem_pc_reg + 32'd4;
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Buffer storage needs no reset: count gates every read.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && wr_ptr_reg == PW'(gi)) begin
          pc_buf[gi]    <= mem_pc_reg;
          instr_buf[gi] <= bus.mem_instr;
        end
      end
    end
  endgenerate

  assign bus.mem_pc   = mem_pc_reg;
  assign bus.count    = count_reg;
  assign bus.id_valid = (count_reg != '0);
  assign bus.id_instr = (count_reg != '0) ? instr_buf[rd_ptr_reg] : NOP;
  assign bus.id_pc    = (count_reg != '0) ? pc_buf[rd_ptr_reg]    : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table, hand-written reset and wrap sequences,
// and a randomized run compared against a queue-based reference model.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk;
  logic rst_n;

  fetch_unit_if #(.DEPTH(DEPTH)) bus();

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH),
    .NOP      (NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ecnt, input logic [31:0] einstr,
                           input logic [31:0] epc, input logic [31:0] emp);
    chk({tag, ".count"},    32'(bus.count), 32'(ecnt));
    chk({tag, ".id_valid"}, 32'(bus.id_valid), (ecnt != 0) ? 32'd1 : 32'd0);
    chk({tag, ".id_instr"}, bus.id_instr, einstr);
    chk({tag, ".id_pc"},    bus.id_pc, epc);
    chk({tag, ".mem_pc"},   bus.mem_pc, emp);
  endtask

  task automatic drive(input logic rdy, input logic [31:0] instr, input logic idr,
                       input logic redir, input logic [31:0] rpc);
    bus.mem_ready      = rdy;
    bus.mem_instr      = instr;
    bus.id_ready       = idr;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
  endtask

  typedef struct {
    logic        rdy;
    logic [31:0] instr;
    logic        idr;
    logic        redir;
    logic [31:0] rpc;
    int          ecnt;
    logic [31:0] einstr;
    logic [31:0] epc;
    logic [31:0] emp;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs[NVEC];

  // Reference model: the buffer as a queue of {pc, instr}, plus the fetch PC and the discard flag.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
  entry_t      mq[$];
  logic [31:0] m_pc;
  bit          m_drop;

  task automatic model_step(input logic rdy, input logic [31:0] instr, input logic idr,
                            input logic redir, input logic [31:0] rpc);
    bit do_pop, do_push;
    entry_t e;
    if (redir) begin
      mq.delete();
      m_pc   = rpc & 32'hFFFF_FFFC;
      m_drop = 1'b1;
    end else begin
      do_pop  = (mq.size() > 0) && idr;
      do_push = rdy && !m_drop && ((mq.size() < DEPTH) || do_pop);
      if (rdy && m_drop) m_drop = 1'b0;
      if (do_pop) begin
        e = mq.pop_front();
        $display("pop pc=%h instr=%h", e.pc, e.instr);
      end
      if (do_push) begin
        e.pc = m_pc;
        e.instr = instr;
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_model(input string tag);
    if (mq.size() > 0) check_all(tag, mq.size(), mq[0].instr, mq[0].pc, m_pc);
    else               check_all(tag, 0, NOP, 32'h0, m_pc);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 0, NOP, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0, 0, NOP, 32'h0, 32'h0};
    vecs[2]  = '{1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0, 1, 32'h0050_0093, 32'h0, 32'h4};
    vecs[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 0, NOP, 32'h0, 32'h4};
    vecs[4]  = '{1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h0, 1, 32'h1111_1111, 32'h4, 32'h8};
    vecs[5]  = '{1'b1, 32'h2222_2222, 1'b1, 1'b0, 32'h0, 1, 32'h2222_2222, 32'h8, 32'hC};
    vecs[6]  = '{1'b1, 32'h3333_3333, 1'b1, 1'b0, 32'h0, 1, 32'h3333_3333, 32'hC, 32'h10};
    vecs[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 0, NOP, 32'h0, 32'h10};
    vecs[8]  = '{1'b1, 32'hA000_0001, 1'b0, 1'b0, 32'h0, 1, 32'hA000_0001, 32'h10, 32'h14};
    vecs[9]  = '{1'b1, 32'hA000_0002, 1'b0, 1'b0, 32'h0, 2, 32'hA000_0001, 32'h10, 32'h18};
    vecs[10] = '{1'b1, 32'hA000_0003, 1'b0, 1'b0, 32'h0, 2, 32'hA000_0001, 32'h10, 32'h18};
    vecs[11] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1, 32'hA000_0002, 32'h14, 32'h18};
    vecs[12] = '{1'b1, 32'hA000_0004, 1'b0, 1'b0, 32'h0, 2, 32'hA000_0002, 32'h14, 32'h1C};
    vecs[13] = '{1'b1, 32'hA000_0005, 1'b1, 1'b0, 32'h0, 2, 32'hA000_0004, 32'h18, 32'h20};
    vecs[14] = '{1'b1, 32'hBBBB_BBBB, 1'b1, 1'b1, 32'h42, 0, NOP, 32'h0, 32'h40};
    vecs[15] = '{1'b1, 32'hCCCC_CCCC, 1'b0, 1'b0, 32'h0, 0, NOP, 32'h0, 32'h40};
    vecs[16] = '{1'b1, 32'hA000_0006, 1'b0, 1'b0, 32'h0, 1, 32'hA000_0006, 32'h40, 32'h44};
    vecs[17] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h100, 0, NOP, 32'h0, 32'h100};
    vecs[18] = '{1'b1, 32'hDDDD_DDDD, 1'b0, 1'b1, 32'h203, 0, NOP, 32'h0, 32'h200};
    vecs[19] = '{1'b1, 32'hEEEE_EEEE, 1'b0, 1'b0, 32'h0, 0, NOP, 32'h0, 32'h200};
    vecs[20] = '{1'b1, 32'hA000_0007, 1'b0, 1'b0, 32'h0, 1, 32'hA000_0007, 32'h200, 32'h204};
    vecs[21] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 0, NOP, 32'h0, 32'hFFFF_FFFC};
    vecs[22] = '{1'b1, 32'hFFFF_0000, 1'b0, 1'b0, 32'h0, 0, NOP, 32'h0, 32'hFFFF_FFFC};
    vecs[23] = '{1'b1, 32'hA000_0008, 1'b0, 1'b0, 32'h0, 1, 32'hA000_0008, 32'hFFFF_FFFC, 32'h0};

    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset", 0, NOP, 32'h0, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rdy, vecs[i].instr, vecs[i].idr, vecs[i].redir, vecs[i].rpc);
      @(negedge clk);
      $display("vec %0d: rdy=%0b idr=%0b redir=%0b -> count=%0d id_pc=%h mem_pc=%h",
               i, vecs[i].rdy, vecs[i].idr, vecs[i].redir, bus.count, bus.id_pc, bus.mem_pc);
      check_all($sformatf("vec%0d", i), vecs[i].ecnt, vecs[i].einstr, vecs[i].epc, vecs[i].emp);
    end

    // Fill the buffer, then pull reset low between clock edges.
    drive(1'b1, 32'hA000_0009, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_all("fill2", 2, 32'hA000_0008, 32'hFFFF_FFFC, 32'h4);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset asserted mid-cycle: count=%0d mem_pc=%h", bus.count, bus.mem_pc);
    check_all("async_rst", 0, NOP, 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_all("post_rst_drop", 0, NOP, 32'h0, 32'h0);
    drive(1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_all("post_rst_accept", 1, 32'h0050_0093, 32'h0, 32'h4);

    // Randomized run against the reference model, starting from a fresh reset.
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    m_pc   = 32'h0;
    m_drop = 1'b1;
    for (int c = 0; c < 400; c++) begin
      logic        r_rdy, r_idr, r_redir;
      logic [31:0] r_instr, r_rpc;
      r_rdy   = ($urandom_range(0, 1) == 1);
      r_idr   = ($urandom_range(0, 2) != 0);
      r_redir = ($urandom_range(0, 15) == 0);
      r_instr = $urandom;
      r_rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      drive(r_rdy, r_instr, r_idr, r_redir, r_rpc);
      model_step(r_rdy, r_instr, r_idr, r_redir, r_rpc);
      @(negedge clk);
      check_model($sformatf("rand%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
